sys_pll_reset_seq: RTL and testbench
====================================

SYS_PLL_RESET_SEQ -- requirements
Module: sys_pll_reset_seq

Interface
REQ-001 SHALL provide parameter NUM_DOM, default 3: number of sequenced output clock domains (1..8).
REQ-002 SHALL provide parameter PLL_RST_CYCLES, default 16: pll_rst pulse width in refclk cycles (>=1).
REQ-003 SHALL provide parameter LOCK_TIMEOUT, default 65535: maximum WAIT_LOCK cycles before a PLL reset retry.
REQ-004 SHALL provide parameter LOCK_STABLE, default 1024: cycles of continuous lock required before any release (>=1).
REQ-005 SHALL provide parameter STAGGER, default 64: cycles between successive domain releases (>=1).
REQ-006 SHALL provide port refclk  in  1  the only clock; all logic is synchronous to it.
REQ-007 SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL provide port pll_locked  in  1  PLL lock, asynchronous to refclk.
REQ-009 SHALL provide port pll_rst  out  1  reset to the PLL, active-high.
REQ-010 SHALL provide port dom_rst  out  NUM_DOM  per-domain reset, active-high; bit i covers PLL outclk_i.
REQ-011 SHALL provide port ready  out  1  all domains released and lock present.
REQ-012 SHALL provide port timeout_err  out  1  sticky: at least one lock timeout since rst.
REQ-013 SHALL provide port loss_cnt  out  8  lock-loss event count, saturating.

Function
REQ-014 SHALL synchronise pll_locked through two flops; every use below refers to the synchronised value (lk).
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, driven by a single down-counting timer sized for the largest parameter.
REQ-016 PLL_RST: SHALL hold pll_rst=1 and dom_rst all-ones for exactly PLL_RST_CYCLES cycles, then enter WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lk=1 -> STABLE; after LOCK_TIMEOUT cycles without lk -> set timeout_err and enter PLL_RST.
REQ-018 STABLE: SHALL count LOCK_STABLE consecutive cycles of lk=1 and then enter RELEASE; lk=0 at any point -> WAIT_LOCK with a fresh timeout. A drop here is not counted as a loss.
REQ-019 RELEASE: SHALL clear dom_rst[0] on entry, then clear dom_rst[i] STAGGER cycles after dom_rst[i-1]; once the last bit clears, it SHALL enter RUN.
REQ-020 RUN: ready=1; dom_rst=0.
REQ-021 lk=0 in RELEASE or RUN SHALL, in the next cycle, set dom_rst all-ones, clear ready, increment loss_cnt (saturating at 255), and enter PLL_RST.
REQ-022 Released bits SHALL never re-assert individually; all bits re-assert together only per REQ-021 or rst.
REQ-023 ready SHALL rise in the cycle after the last dom_rst bit clears.
REQ-024 Latency: with lk steady, the clear of dom_rst[0] SHALL occur 2+LOCK_STABLE+1 cycles after pll_locked rises (±1 cycle for synchroniser sampling).

Reset
REQ-025 While rst=1: state=PLL_RST with the timer loaded, pll_rst=1, dom_rst=all-ones, ready=0, timeout_err=0, loss_cnt=0, synchroniser flops=0.
REQ-026 rst asserted in any state, mid-sequence included, SHALL take effect on the next edge; the PLL_RST count SHALL start on the first cycle with rst=0.

Configuration
REQ-027 With SYS_PLL_SEQ_LOSS_CNT_EN defined, loss_cnt behaves per REQ-021.
REQ-028 Without SYS_PLL_SEQ_LOSS_CNT_EN, loss_cnt SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package sys_pll_seq_pkg SHALL hold the state enum type and the loss counter width constant (8).
REQ-030 The two-flop synchroniser SHALL be a separate sub-module, pll_lock_sync; the FSM, timer and counters SHALL stay in sys_pll_reset_seq.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, STAGGER=2, NUM_DOM=3)
REQ-031 rst 1->0, pll_locked=1 from cycle 10 -> pll_rst high for 4 cycles; dom_rst 111->110->100->000 at 2-cycle spacing; ready=1 one cycle after 000.
REQ-032 pll_locked held 0 -> timeout_err=1 after 100 WAIT_LOCK cycles; pll_rst re-pulses for 4 cycles; retries repeat every 104 cycles.
REQ-033 pll_locked drops 1 cycle in STABLE at count 5 -> back to WAIT_LOCK; full 8-cycle stable count restarts; loss_cnt=0.
REQ-034 pll_locked drops in RUN -> dom_rst=111 and ready=0 the cycle after lk falls; loss_cnt=1; full sequence repeats; 300 drops -> loss_cnt=255 (0 when macro undefined).
REQ-035 rst pulsed 1 cycle during RELEASE with dom_rst=110 -> next cycle dom_rst=111, pll_rst=1, timeout_err and loss_cnt cleared.

Source files
------------

// File: rtl/sys_pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding,
// loss counter width and timer sizing helpers.
package sys_pll_seq_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } sys_pll_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The timer is loaded with (count - 1), so it only has to hold max_cycles - 1.
  function automatic int timer_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock indication into
// the refclk domain; both flops clear on the synchronous reset.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_lock,
  output logic lk
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_lock;
      sync_q <= meta_q;
    end
  end

  assign lk = sync_q;

endmodule

// File: rtl/sys_pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases per-domain resets one by one. Optional loss counter: SYS_PLL_SEQ_LOSS_CNT_EN.
module sys_pll_reset_seq
  import sys_pll_seq_pkg::*;
#(
  parameter int NUM_DOM        = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGGER        = 64
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_DOM-1:0]    dom_rst,
  output logic                  ready,
  output logic                  timeout_err,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output sys_pll_state_e        state_dbg
);

  localparam int TIMER_MAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, STAGGER);
  localparam int TW        = timer_width(TIMER_MAX);

  localparam logic [TW-1:0] T_PLL_RST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STABLE  = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] T_STAGGER = TW'(STAGGER - 1);

  logic                 lk;
  sys_pll_state_e       state_q;
  sys_pll_state_e       state_d;
  logic [TW-1:0]        timer_q;
  logic [TW-1:0]        timer_d;
  logic [NUM_DOM-1:0]   dom_rst_q;
  logic [NUM_DOM-1:0]   dom_rst_d;
  logic                 timeout_set;
  logic                 timeout_err_q;

  pll_lock_sync u_lock_sync (
    .clk        (refclk),
    .rst        (rst),
    .async_lock (pll_locked),
    .lk         (lk)
  );

  // State, timer and domain-reset registers; rst reloads the PLL reset count.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= T_PLL_RST;
      dom_rst_q <= '1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dom_rst_q <= dom_rst_d;
    end
  end

  // dom_rst only ever shifts zeros in from bit 0, so a released domain can
  // come back into reset only through the all-ones reload on lock loss.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dom_rst_d   = dom_rst_q;
    timeout_set = 1'b0;
    unique case (state_q)
      ST_PLL_RST: begin
        dom_rst_d = '1;
        if (timer_q == '0) begin
          state_d = ST_WAIT_LOCK;
          timer_d = T_TIMEOUT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
          timer_d = T_STABLE;
        end else if (timer_q == '0) begin
          state_d     = ST_PLL_RST;
          timer_d     = T_PLL_RST;
          timeout_set = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          timer_d = T_TIMEOUT;
        end else if (timer_q == '0) begin
          state_d   = ST_RELEASE;
          timer_d   = T_STAGGER;
          dom_rst_d = dom_rst_q << 1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lk) begin
          state_d   = ST_PLL_RST;
          timer_d   = T_PLL_RST;
          dom_rst_d = '1;
        end else if (dom_rst_q == '0) begin
          state_d = ST_RUN;
        end else if (timer_q == '0) begin
          timer_d   = T_STAGGER;
          dom_rst_d = dom_rst_q << 1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d   = ST_PLL_RST;
          timer_d   = T_PLL_RST;
          dom_rst_d = '1;
        end
      end
      default: begin
        state_d   = ST_PLL_RST;
        timer_d   = T_PLL_RST;
        dom_rst_d = '1;
      end
    endcase
  end

  always_comb begin
    pll_rst   = 1'b0;
    ready     = 1'b0;
    dom_rst   = dom_rst_q;
    state_dbg = state_q;
    if (state_q == ST_PLL_RST) pll_rst = 1'b1;
    if (state_q == ST_RUN)     ready   = 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;

`ifdef SYS_PLL_SEQ_LOSS_CNT_EN
  // A drop during STABLE is a failed lock attempt, not a loss of an established lock.
  logic                  loss_event;
  logic [LOSS_CNT_W-1:0] loss_q;

  assign loss_event = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lk;

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_pll_reset_seq.sv
// Directed bench for sys_pll_reset_seq: expected output vectors are queued as
// each step is driven and compared one refclk edge later.
module tb_sys_pll_reset_seq;
  import sys_pll_seq_pkg::*;

  localparam int NUM_DOM        = 3;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 100;
  localparam int LOCK_STABLE    = 8;
  localparam int STAGGER        = 2;
  localparam int W              = 1 + NUM_DOM + 1 + 1 + LOSS_CNT_W;

`ifdef SYS_PLL_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic                  refclk = 1'b0;
  logic                  rst;
  logic                  pll_locked;
  logic                  pll_rst;
  logic [NUM_DOM-1:0]    dom_rst;
  logic                  ready;
  logic                  timeout_err;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  sys_pll_state_e        state_dbg;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  sys_pll_reset_seq #(
    .NUM_DOM        (NUM_DOM),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .LOCK_STABLE    (LOCK_STABLE),
    .STAGGER        (STAGGER)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .dom_rst     (dom_rst),
    .ready       (ready),
    .timeout_err (timeout_err),
    .loss_cnt    (loss_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] mk(input logic pr, input logic [NUM_DOM-1:0] dr,
                                       input logic rdy, input logic te,
                                       input logic [LOSS_CNT_W-1:0] l);
    return {pr, dr, rdy, te, l};
  endfunction

  function automatic logic [LOSS_CNT_W-1:0] lc(input int n);
    if (!LOSS_EN) return '0;
    return (n > 255) ? 8'd255 : n[7:0];
  endfunction

  // scoreboard
  task automatic compare_front();
    logic [W-1:0] e;
    logic [W-1:0] o;
    string        t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pll_rst, dom_rst, ready, timeout_err, loss_cnt};
    check_cnt++;
    assert (o === e) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // driver: queue expectation, advance one edge, compare
  task automatic step(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge refclk);
    #1;
    compare_front();
  endtask

  task automatic expect_release(input logic te, input logic [LOSS_CNT_W-1:0] l);
    repeat (2) step("rel_110", mk(1'b0, 3'b110, 1'b0, te, l));
    repeat (2) step("rel_100", mk(1'b0, 3'b100, 1'b0, te, l));
    step("rel_000", mk(1'b0, 3'b000, 1'b0, te, l));
    step("ready_rise", mk(1'b0, 3'b000, 1'b1, te, l));
  endtask

  // One-cycle pll_locked drop while in RUN, then the full resequence back to RUN.
  task automatic glitch_in_run(input int drops_before);
    logic [LOSS_CNT_W-1:0] lp;
    logic [LOSS_CNT_W-1:0] ln;
    lp = lc(drops_before);
    ln = lc(drops_before + 1);
    pll_locked = 1'b0;
    step("run_before_loss", mk(1'b0, 3'b000, 1'b1, 1'b0, lp));
    pll_locked = 1'b1;
    step("run_lk_in_sync", mk(1'b0, 3'b000, 1'b1, 1'b0, lp));
    repeat (4) step("loss_pll_rst", mk(1'b1, 3'b111, 1'b0, 1'b0, ln));
    repeat (9) step("loss_relock", mk(1'b0, 3'b111, 1'b0, 1'b0, ln));
    expect_release(1'b0, ln);
  endtask

  initial begin
    logic [LOSS_CNT_W-1:0] l_sat;

    // reset state and first power-up sequence, lock arriving at cycle 10
    rst        = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step("reset_state", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    check_cnt++;
    assert (state_dbg === ST_PLL_RST) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL reset_fsm_state observed=%0d expected=%0d", state_dbg, ST_PLL_RST);
    end
    rst = 1'b0;
    repeat (3) step("pll_rst_width", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    repeat (6) step("wait_lock_idle", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    pll_locked = 1'b1;
    repeat (10) step("lock_stable_count", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    expect_release(1'b0, 8'd0);
    repeat (3) step("run_hold", mk(1'b0, 3'b000, 1'b1, 1'b0, 8'd0));

    // single lock loss in RUN
    glitch_in_run(0);

    // drop during STABLE restarts the full stable count and is not a loss
    rst = 1'b1;
    step("reset_clears_loss", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    rst = 1'b0;
    repeat (3) step("pll_rst_width2", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    repeat (5) step("stable_pre_drop", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    pll_locked = 1'b0;
    step("stable_drop", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    pll_locked = 1'b1;
    repeat (10) step("stable_restart", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    expect_release(1'b0, 8'd0);

    // 300 losses: counter saturates at 255
    for (int i = 0; i < 300; i++) glitch_in_run(i);
    step("run_after_drops", mk(1'b0, 3'b000, 1'b1, 1'b0, lc(300)));

    // lock lost for good: timeout, retry every 104 cycles
    l_sat      = lc(301);
    pll_locked = 1'b0;
    repeat (2) step("run_before_hold_low", mk(1'b0, 3'b000, 1'b1, 1'b0, lc(300)));
    repeat (4) step("hold_low_pll_rst", mk(1'b1, 3'b111, 1'b0, 1'b0, l_sat));
    repeat (100) step("wait_lock_to_timeout", mk(1'b0, 3'b111, 1'b0, 1'b0, l_sat));
    repeat (4) step("timeout_retry_pulse", mk(1'b1, 3'b111, 1'b0, 1'b1, l_sat));
    repeat (100) step("second_wait_lock", mk(1'b0, 3'b111, 1'b0, 1'b1, l_sat));
    repeat (4) step("retry_period", mk(1'b1, 3'b111, 1'b0, 1'b1, l_sat));
    pll_locked = 1'b1;
    repeat (10) step("relock_after_timeout", mk(1'b0, 3'b111, 1'b0, 1'b1, l_sat));
    step("release_first_bit", mk(1'b0, 3'b110, 1'b0, 1'b1, l_sat));

    // rst pulse mid-RELEASE clears everything next edge
    rst = 1'b1;
    step("rst_in_release", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    rst = 1'b0;
    repeat (3) step("pll_rst_after_rst", mk(1'b1, 3'b111, 1'b0, 1'b0, 8'd0));
    repeat (9) step("relock_after_rst", mk(1'b0, 3'b111, 1'b0, 1'b0, 8'd0));
    expect_release(1'b0, 8'd0);
    repeat (2) step("final_run", mk(1'b0, 3'b000, 1'b1, 1'b0, 8'd0));

    // report
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
